alu_mdu: RTL and testbench

- Parametrised next-generation ALU for the MIPS datapath.
- Keeps the single-cycle ALU operations (AND, OR, ADD, SUB, SLT, SLL) and their control codes.
- Adds SRL, SRA, signed overflow detection, and an iterative multiply/divide unit with HI/LO registers.
- Every operation runs through a start/done handshake, so the control unit can stall on multi-cycle ops.

---
 rtl/alu_mdu.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_mdu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle MIPS ALU plus an iterative multiply/divide unit
// with HI/LO registers. Every operation completes through a start/done
// handshake; multiply/divide take WIDTH iterations and hold busy meanwhile.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   sll,
  output logic [WIDTH-1:0] aluout,
  output logic             zeroflag,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SRL   = 4'd3;
  localparam logic [3:0] OP_SRA   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MFHI  = 4'd12;
  localparam logic [3:0] OP_MFLO  = 4'd13;
  localparam logic [3:0] OP_SLL   = 4'd15;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_reg, state_next;
  logic [SHW-1:0]     count_reg, count_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;       // {upper, lower} working register
  logic [WIDTH-1:0]   op_reg, op_next;         // multiplicand or divisor magnitude
  logic               neg_lo_reg, neg_lo_next; // negate product / quotient at the end
  logic               neg_hi_reg, neg_hi_next; // negate remainder at the end
  logic               divz_reg, divz_next;     // divisor was zero
  logic [WIDTH-1:0]   aluout_reg, aluout_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               ovf_reg, ovf_next;
  logic               done_reg, done_next;

  // single-cycle datapath
  logic [WIDTH-1:0] add_sum, sub_dif, alu_res;
  logic             alu_ovf;

  // operand conditioning for multiply/divide (magnitudes and signs)
  logic             is_mdu, is_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // one iteration of shift-add multiply and restoring divide
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_dif;
  logic [2*WIDTH-1:0] div_step;

  // sign-corrected final results, applied on the last iteration
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;
  logic               last_iter;

  assign add_sum = in1 + in2;
  assign sub_dif = in1 - in2;

  // MULT/DIV are the even codes of 8..11, the unsigned variants are odd
  assign is_mdu    = (aluctrl[3:2] == 2'b10);
  assign is_div    = aluctrl[1];
  assign op_signed = ~aluctrl[0];
  assign a_neg     = op_signed & in1[WIDTH-1];
  assign b_neg     = op_signed & in2[WIDTH-1];
  assign mag_a     = a_neg ? (~in1 + 1'b1) : in1;
  assign mag_b     = b_neg ? (~in2 + 1'b1) : in2;

  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_reg[0] ? op_reg : {WIDTH{1'b0}})};
  assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

  // partial remainder is always below the divisor, so the difference fits WIDTH bits
  assign div_trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, op_reg});
  assign div_dif   = div_trial[WIDTH-1:0] - op_reg;
  assign div_step  = div_ge ? {div_dif, acc_reg[WIDTH-2:0], 1'b1}
                            : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

  // remainder magnitude equals |in1| on divide-by-zero, so the sign fix restores in1
  assign prod_fix  = neg_lo_reg ? (~mul_step + 1'b1) : mul_step;
  assign quo       = div_step[WIDTH-1:0];
  assign rem       = div_step[2*WIDTH-1:WIDTH];
  assign quo_fix   = divz_reg ? {WIDTH{1'b1}} : (neg_lo_reg ? (~quo + 1'b1) : quo);
  assign rem_fix   = neg_hi_reg ? (~rem + 1'b1) : rem;
  assign last_iter = (count_reg == SHW'(WIDTH - 1));

  // single-cycle result and signed overflow for the current request
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (aluctrl)
      OP_AND:  alu_res = in1 & in2;
      OP_OR:   alu_res = in1 | in2;
      OP_ADD: begin
        alu_res = add_sum;
        alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_dif;
        alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_dif[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLL:  alu_res = in2 << sll;
      OP_SRL:  alu_res = in2 >> sll;
      OP_SRA:  alu_res = $unsigned($signed(in2) >>> sll);
      OP_MFHI: alu_res = hi_reg;
      OP_MFLO: alu_res = lo_reg;
      default: alu_res = '0;
    endcase
  end

  // next-state and datapath updates for the handshake FSM
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    acc_next    = acc_reg;
    op_next     = op_reg;
    neg_lo_next = neg_lo_reg;
    neg_hi_next = neg_hi_reg;
    divz_next   = divz_reg;
    aluout_next = aluout_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    ovf_next    = ovf_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (is_mdu) begin
            count_next  = '0;
            neg_lo_next = a_neg ^ b_neg;
            neg_hi_next = a_neg;
            divz_next   = (in2 == '0);
            if (is_div) begin
              state_next = DIV;
              op_next    = mag_b;
              acc_next   = {{WIDTH{1'b0}}, mag_a};
            end else begin
              state_next = MUL;
              op_next    = mag_a;
              acc_next   = {{WIDTH{1'b0}}, mag_b};
            end
          end else begin
            aluout_next = alu_res;
            ovf_next    = alu_ovf;
            done_next   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next   = mul_step;
        count_next = count_reg + SHW'(1);
        if (last_iter) begin
          state_next  = DONE;
          hi_next     = prod_fix[2*WIDTH-1:WIDTH];
          lo_next     = prod_fix[WIDTH-1:0];
          aluout_next = prod_fix[WIDTH-1:0];
          done_next   = 1'b1;
        end
      end
      DIV: begin
        acc_next   = div_step;
        count_next = count_reg + SHW'(1);
        if (last_iter) begin
          state_next  = DONE;
          hi_next     = rem_fix;
          lo_next     = quo_fix;
          aluout_next = quo_fix;
          done_next   = 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // state and datapath registers; reset also aborts any multiply/divide in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      op_reg     <= '0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      divz_reg   <= 1'b0;
      aluout_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      acc_reg    <= acc_next;
      op_reg     <= op_next;
      neg_lo_reg <= neg_lo_next;
      neg_hi_reg <= neg_hi_next;
      divz_reg   <= divz_next;
      aluout_reg <= aluout_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      ovf_reg    <= ovf_next;
      done_reg   <= done_next;
    end
  end

  assign aluout   = aluout_reg;
  assign zeroflag = (aluout_reg == '0);
  assign overflow = ovf_reg;
  assign busy     = (state_reg == MUL) || (state_reg == DIV);
  assign done     = done_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32): directed cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_alu_mdu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  aluctrl;
  logic [31:0] in1, in2;
  logic [4:0]  sll;
  logic [31:0] aluout, hi, lo;
  logic        zeroflag, overflow, busy, done;

  int checks = 0;
  int failures = 0;

  // reference architectural state
  logic [31:0] m_aluout, m_hi, m_lo;
  logic        m_ovf;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .aluctrl(aluctrl),
    .in1(in1), .in2(in2), .sll(sll),
    .aluout(aluout), .zeroflag(zeroflag), .overflow(overflow),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd15: return b << sh;
      4'd3:  return b >> sh;
      4'd4:  return $unsigned($signed(b) >>> sh);
      4'd12: return m_hi;
      4'd13: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint s;
    ia = a;
    ib = b;
    if (c == 4'd2) s = longint'(ia) + longint'(ib);
    else if (c == 4'd6) s = longint'(ia) - longint'(ib);
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic model_mdu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] ehi, output logic [31:0] elo);
    int ia, ib;
    longint sa, sb, q, r;
    logic [63:0] p;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ehi = '0;
    elo = '0;
    case (c)
      4'd8: begin
        p = sa * sb;
        ehi = p[63:32];
        elo = p[31:0];
      end
      4'd9: begin
        p = {32'd0, a} * {32'd0, b};
        ehi = p[63:32];
        elo = p[31:0];
      end
      4'd10: begin
        if (b == 0) begin
          ehi = a;
          elo = '1;
        end else begin
          q = sa / sb;
          r = sa % sb;
          ehi = r[31:0];
          elo = q[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          ehi = a;
          elo = '1;
        end else begin
          ehi = a % b;
          elo = a / b;
        end
      end
    endcase
  endtask

  // issue one request from IDLE and check it; poke pulses an ignored ADD mid-operation
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input bit poke);
    logic [31:0] ehi, elo;
    int n, busy_cnt;
    bit hold_bad, seen;
    aluctrl = c; in1 = a; in2 = b; sll = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (c inside {[8:11]}) begin
      model_mdu(c, a, b, ehi, elo);
      check("busy_rise", busy, 1);
      check("done_early", done, 0);
      busy_cnt = 1; hold_bad = 0; seen = 0; n = 0;
      while (!seen && n < 40) begin
        if (poke && n == 5) begin
          start = 1'b1; aluctrl = 4'd2; in1 = $urandom; in2 = $urandom;
        end
        @(posedge clk); #1;
        start = 1'b0;
        n++;
        if (done) seen = 1;
        else begin
          if (busy) busy_cnt++;
          if (aluout !== m_aluout || hi !== m_hi || lo !== m_lo) hold_bad = 1;
        end
      end
      check("mdu_latency", n, 32);
      check("busy_cycles", busy_cnt, 32);
      check("hold_during_busy", hold_bad, 0);
      m_hi = ehi; m_lo = elo; m_aluout = elo;
      check("mdu_hi", hi, m_hi);
      check("mdu_lo", lo, m_lo);
      check("mdu_aluout", aluout, m_aluout);
      check("mdu_busy_at_done", busy, 0);
      check("mdu_zero", zeroflag, (m_aluout == 0));
      check("mdu_ovf_hold", overflow, m_ovf);
    end else begin
      m_aluout = model_res(c, a, b, sh);
      m_ovf = model_ovf(c, a, b);
      check("alu_done", done, 1);
      check("alu_out", aluout, m_aluout);
      check("alu_ovf", overflow, m_ovf);
      check("alu_zero", zeroflag, (m_aluout == 0));
      check("alu_hi_keep", hi, m_hi);
      check("alu_lo_keep", lo, m_lo);
    end
    $display("txn op=%0d a=%h b=%h sh=%0d aluout=%h ovf=%0b hi=%h lo=%h",
             c, a, b, sh, aluout, overflow, hi, lo);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; aluctrl = 4'd2; in1 = 32'd5; in2 = 32'd3; sll = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_aluout", aluout, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zeroflag, 1);
    check("rst_ovf", overflow, 0);
    rst = 1'b0; start = 1'b0;
    m_aluout = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0;

    // directed single-cycle cases
    do_op(4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 0);
    check("add_ovf_directed", overflow, 1);
    do_op(4'd6, 32'd5, 32'd5, 5'd0, 0);
    do_op(4'd4, 32'd0, 32'h8000_0000, 5'd4, 0);
    check("sra_directed", aluout, 32'hF800_0000);
    do_op(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
    check("slt_directed", aluout, 1);

    // back-to-back issue with start held high
    aluctrl = 4'd2; in1 = 32'd10; in2 = 32'd20; start = 1'b1;
    @(posedge clk); #1;
    check("b2b_first", aluout, 32'd30);
    check("b2b_first_done", done, 1);
    aluctrl = 4'd1; in1 = 32'hF0; in2 = 32'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second", aluout, 32'hFF);
    check("b2b_second_done", done, 1);
    m_aluout = 32'hFF; m_ovf = 1'b0;
    @(posedge clk); #1;

    // directed multiply / divide cases
    do_op(4'd8, 32'hFFFF_FFFD, 32'd7, 5'd0, 0);
    check("mult_hi_directed", hi, 32'hFFFF_FFFF);
    check("mult_lo_directed", lo, 32'hFFFF_FFEB);
    do_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0);
    check("multu_hi_directed", hi, 32'hFFFF_FFFE);
    do_op(4'd10, 32'hFFFF_FFF9, 32'd2, 5'd0, 1);
    check("div_lo_directed", lo, 32'hFFFF_FFFD);
    check("div_hi_directed", hi, 32'hFFFF_FFFF);
    do_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    do_op(4'd10, 32'hFFFF_FFF9, 32'd0, 5'd0, 0);
    do_op(4'd11, 32'd7, 32'd0, 5'd0, 0);
    do_op(4'd12, 32'd0, 32'd0, 5'd0, 0);
    check("mfhi_directed", aluout, 32'd7);
    do_op(4'd13, 32'd0, 32'd0, 5'd0, 0);
    check("mflo_directed", aluout, 32'hFFFF_FFFF);

    // abort a multiply at iteration 10
    aluctrl = 4'd8; in1 = 32'h1234_5678; in2 = 32'h0FED_CBA9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_aluout", aluout, 0);
    m_aluout = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0;
    do_op(4'd2, 32'd3, 32'd4, 5'd0, 0);

    // randomized operations
    for (int i = 0; i < 80; i++) begin
      do_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
